// File: rtl/predictor_pkg.sv
// Shared definitions for the predictor trigger responder.
// Holds the FSM state encoding, default parameter values and the
// saturation limits for the default data width.
// Optional feature macro used by this slice: PREDICTOR_SAT_EN.
package predictor_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int ALPHA_SH_DEF = 1;
  localparam int BETA_SH_DEF  = 3;
  localparam int CNT_W_DEF    = 8;

  // Saturation limits for the default data width.
  localparam logic signed [DATA_W_DEF-1:0] SAT_MAX_DEF = 16'sh7FFF;
  localparam logic signed [DATA_W_DEF-1:0] SAT_MIN_DEF = 16'sh8000;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LATCHED   = 2'd1,
    S_UPDATED   = 2'd2,
    S_PREDICTED = 2'd3
  } state_t;

endpackage

// File: rtl/predictor_sat_add.sv
// Combinational signed adder with a DATA_W result.
// Operands are IN_W bits wide; the sum is formed at IN_W+1 bits so it never
// overflows internally, then either clamped (PREDICTOR_SAT_EN defined) or
// truncated to the DATA_W LSBs (two's-complement wrap, default build).
// Ports:
//   a, b : signed IN_W-bit operands
//   sum  : signed DATA_W-bit result
module predictor_sat_add
  import predictor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IN_W   = DATA_W_DEF + 2
) (
  input  logic signed [IN_W-1:0]   a,
  input  logic signed [IN_W-1:0]   b,
  output logic signed [DATA_W-1:0] sum
);

  logic signed [IN_W:0] full;

  assign full = {a[IN_W-1], a} + {b[IN_W-1], b};

`ifdef PREDICTOR_SAT_EN
  // Limits of a DATA_W signed value, sign-extended to the full sum width.
  logic signed [IN_W:0] hi_lim;
  logic signed [IN_W:0] lo_lim;

  assign hi_lim = {{(IN_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  assign lo_lim = {{(IN_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    sum = full[DATA_W-1:0];
    if (full > hi_lim) begin
      sum = hi_lim[DATA_W-1:0];
    end else if (full < lo_lim) begin
      sum = lo_lim[DATA_W-1:0];
    end
  end
`else
  // Wrapping build: upper bits of the wide sum are intentionally dropped.
  logic unused_hi;

  assign unused_hi = ^full[IN_W:DATA_W];
  assign sum       = full[DATA_W-1:0];
`endif

endmodule

// File: rtl/predictor_trigger_responder.sv
// Consumer end of the predictor trigger strobes.
// Runs one fixed-point alpha-beta tracker step per complete
// latch -> update -> predict -> output sequence and flags strobes that
// arrive out of order. Sits between the trigger generator and the
// downstream output register / DAC path.
// Optional feature macro: PREDICTOR_SAT_EN (saturating arithmetic in
// predictor_sat_add; wrapping when undefined).
// Ports:
//   clock           : sole clock, rising edge
//   reset_n         : synchronous active-low reset
//   latch_trigger   : phase 1 strobe, captures meas_in
//   update_trigger  : phase 2 strobe, corrects estimate with residual
//   predict_trigger : phase 3 strobe, computes next prediction
//   output_trigger  : phase 4 strobe, publishes prediction
//   meas_in         : signed measurement, sampled only on latch
//   pred_out        : signed published prediction
//   pred_valid      : 1-cycle pulse when pred_out updates
//   seq_error       : 1-cycle pulse on an illegal strobe
//   step_count      : completed sequences, wrapping
//   err_count       : illegal strobes, saturating
//   fsm_state       : current FSM state (observability)
//
// Handshake: the four strobes carry no ready; each is level-sampled at every
// rising edge and acted on at that same edge. Exactly one strobe matching the
// current state advances the FSM; anything else is an illegal strobe except a
// lone output strobe on the cycle right after a publish, which is ignored.
module predictor_trigger_responder
  import predictor_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ALPHA_SH = ALPHA_SH_DEF,
  parameter int BETA_SH  = BETA_SH_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     latch_trigger,
  input  logic                     update_trigger,
  input  logic                     predict_trigger,
  input  logic                     output_trigger,
  input  logic signed [DATA_W-1:0] meas_in,
  output logic signed [DATA_W-1:0] pred_out,
  output logic                     pred_valid,
  output logic                     seq_error,
  output logic [CNT_W-1:0]         step_count,
  output logic [CNT_W-1:0]         err_count,
  output logic [1:0]               fsm_state
);

  localparam int IN_W = DATA_W + 2;

  state_t state;

  logic signed [DATA_W-1:0] meas_q;
  logic signed [DATA_W-1:0] x_pred;
  logic signed [DATA_W-1:0] x_est;
  logic signed [DATA_W-1:0] v_est;
  logic                     just_pub;

  logic signed [IN_W-1:0]   resid;
  logic signed [IN_W-1:0]   resid_a;
  logic signed [IN_W-1:0]   resid_b;
  logic signed [DATA_W-1:0] x_est_next;
  logic signed [DATA_W-1:0] v_est_next;
  logic signed [DATA_W-1:0] x_pred_next;

  logic [3:0] strobes;
  logic       one_strobe;

  assign fsm_state = state;

  // Residual is kept two bits wider than the data so meas - pred never wraps.
  assign resid   = {{2{meas_q[DATA_W-1]}}, meas_q} - {{2{x_pred[DATA_W-1]}}, x_pred};
  assign resid_a = resid >>> ALPHA_SH;
  assign resid_b = resid >>> BETA_SH;

  predictor_sat_add #(.DATA_W(DATA_W), .IN_W(IN_W)) u_add_x_est (
    .a   ({{2{x_pred[DATA_W-1]}}, x_pred}),
    .b   (resid_a),
    .sum (x_est_next)
  );

  predictor_sat_add #(.DATA_W(DATA_W), .IN_W(IN_W)) u_add_v_est (
    .a   ({{2{v_est[DATA_W-1]}}, v_est}),
    .b   (resid_b),
    .sum (v_est_next)
  );

  predictor_sat_add #(.DATA_W(DATA_W), .IN_W(IN_W)) u_add_x_pred (
    .a   ({{2{x_est[DATA_W-1]}}, x_est}),
    .b   ({{2{v_est[DATA_W-1]}}, v_est}),
    .sum (x_pred_next)
  );

  assign strobes    = {output_trigger, predict_trigger, update_trigger, latch_trigger};
  assign one_strobe = (strobes != 4'd0) && ((strobes & (strobes - 4'd1)) == 4'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      meas_q     <= '0;
      x_pred     <= '0;
      x_est      <= '0;
      v_est      <= '0;
      just_pub   <= 1'b0;
      pred_out   <= '0;
      pred_valid <= 1'b0;
      seq_error  <= 1'b0;
      step_count <= '0;
      err_count  <= '0;
    end else begin
      pred_valid <= 1'b0;
      seq_error  <= 1'b0;
      just_pub   <= 1'b0;

      if (strobes == 4'd0) begin
        // No strobe: hold.
      end else if (!one_strobe) begin
        seq_error <= 1'b1;
        if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
        state <= S_IDLE;
      end else if (latch_trigger) begin
        // A lone latch always restarts the sequence; it is only legal from idle.
        meas_q <= meas_in;
        state  <= S_LATCHED;
        if (state != S_IDLE) begin
          seq_error <= 1'b1;
          if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
        end
      end else if (update_trigger && state == S_LATCHED) begin
        x_est <= x_est_next;
        v_est <= v_est_next;
        state <= S_UPDATED;
      end else if (predict_trigger && state == S_UPDATED) begin
        x_pred <= x_pred_next;
        state  <= S_PREDICTED;
      end else if (output_trigger && state == S_PREDICTED) begin
        pred_out   <= x_pred;
        pred_valid <= 1'b1;
        step_count <= step_count + CNT_W'(1);
        just_pub   <= 1'b1;
        state      <= S_IDLE;
      end else if (output_trigger && state == S_IDLE && just_pub) begin
        // Output strobe stretched into the cycle after a publish: tolerated.
      end else begin
        seq_error <= 1'b1;
        if (err_count != {CNT_W{1'b1}}) err_count <= err_count + CNT_W'(1);
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_predictor_trigger_responder.sv
// Testbench for predictor_trigger_responder (default parameters).
// Build with or without PREDICTOR_SAT_EN; the saturation test adapts.
module tb_predictor_trigger_responder;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset_n = 1'b0;
  logic               latch_trigger = 1'b0;
  logic               update_trigger = 1'b0;
  logic               predict_trigger = 1'b0;
  logic               output_trigger = 1'b0;
  logic signed [15:0] meas_in = '0;
  logic signed [15:0] pred_out;
  logic               pred_valid;
  logic               seq_error;
  logic [7:0]         step_count;
  logic [7:0]         err_count;
  logic [1:0]         fsm_state;

  predictor_trigger_responder dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .latch_trigger   (latch_trigger),
    .update_trigger  (update_trigger),
    .predict_trigger (predict_trigger),
    .output_trigger  (output_trigger),
    .meas_in         (meas_in),
    .pred_out        (pred_out),
    .pred_valid      (pred_valid),
    .seq_error       (seq_error),
    .step_count      (step_count),
    .err_count       (err_count),
    .fsm_state       (fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] exp_q[$];
  bit model_on = 0;
  int m_phase, m_meas, m_xpred, m_xest, m_vest, m_pred_out, m_step, m_err;
  bit m_pv, m_se, m_last_pub;

  function automatic int fit(input int v);
`ifdef PREDICTOR_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
`endif
  endfunction

  task automatic model_err();
    m_se = 1;
    if (m_err < 255) m_err++;
    m_phase = 0;
  endtask

  always @(posedge clock) begin
    int n, r;
    bit pub_prev;
    if (!reset_n) begin
      m_phase = 0; m_meas = 0; m_xpred = 0; m_xest = 0; m_vest = 0;
      m_pred_out = 0; m_step = 0; m_err = 0; m_pv = 0; m_se = 0; m_last_pub = 0;
      exp_q.delete();
      model_on = 1;
    end else begin
      n = int'(latch_trigger) + int'(update_trigger) + int'(predict_trigger) + int'(output_trigger);
      pub_prev = m_last_pub;
      m_last_pub = 0; m_pv = 0; m_se = 0;
      if (n == 0) begin
      end else if (n > 1) begin
        model_err();
      end else if (latch_trigger) begin
        if (m_phase != 0) model_err();
        m_meas = int'(meas_in);
        m_phase = 1;
      end else if (update_trigger && m_phase == 1) begin
        r = m_meas - m_xpred;
        m_xest = fit(m_xpred + (r >>> 1));
        m_vest = fit(m_vest + (r >>> 3));
        m_phase = 2;
      end else if (predict_trigger && m_phase == 2) begin
        m_xpred = fit(m_xest + m_vest);
        m_phase = 3;
      end else if (output_trigger && m_phase == 3) begin
        m_pred_out = m_xpred;
        m_pv = 1;
        m_step = (m_step + 1) % 256;
        m_last_pub = 1;
        exp_q.push_back(m_xpred[15:0]);
        m_phase = 0;
      end else if (output_trigger && m_phase == 0 && pub_prev) begin
      end else begin
        model_err();
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  int pv_seen = 0;
  int se_seen = 0;

  always @(negedge clock) begin
    logic [15:0] e;
    if (model_on) begin
      check("pred_out", int'(pred_out), m_pred_out);
      check("pred_valid", int'(pred_valid), int'(m_pv));
      check("seq_error", int'(seq_error), int'(m_se));
      check("step_count", int'(step_count), m_step);
      check("err_count", int'(err_count), m_err);
      check("fsm_state", int'(fsm_state), m_phase);
      if (pred_valid) begin
        pv_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_publish", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("published_value", int'(pred_out[15:0]), int'(e));
        end
      end
      if (seq_error) se_seen++;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input bit l, input bit u, input bit p, input bit o, input int m);
    @(negedge clock);
    #1;
    latch_trigger   = l;
    update_trigger  = u;
    predict_trigger = p;
    output_trigger  = o;
    meas_in         = 16'(m);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic seq(input int m);
    drive(1, 0, 0, 0, m);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    idle(1);
  endtask

  task automatic set_reset(input bit v);
    @(negedge clock);
    #1;
    reset_n = v;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int pv0, se0, min_seen, after3;

    // 1: reset, then idle
    idle(3);
    set_reset(1);
    pv0 = pv_seen; se0 = se_seen;
    idle(10);
    check("idle_pred_valid_pulses", pv_seen - pv0, 0);
    check("idle_seq_error_pulses", se_seen - se0, 0);
    check("reset_pred_out", int'(pred_out), 0);
    check("reset_state", int'(fsm_state), 0);

    // 2: one legal sequence, meas=100 -> 62
    pv0 = pv_seen;
    seq(100);
    check("seq1_pred_out", int'(pred_out), 62);
    check("seq1_step_count", int'(step_count), 1);
    check("seq1_pulses", pv_seen - pv0, 1);

    // 3: output strobe held two cycles -> one publish, no error (97)
    pv0 = pv_seen; se0 = se_seen;
    drive(1, 0, 0, 0, 100);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    idle(1);
    check("held_out_pred_out", int'(pred_out), 97);
    check("held_out_pulses", pv_seen - pv0, 1);
    check("held_out_errors", se_seen - se0, 0);
    check("held_out_err_count", int'(err_count), 0);

    // 4: predict while latched -> error, x_pred kept (next step gives 113)
    se0 = se_seen;
    drive(1, 0, 0, 0, 200);
    drive(0, 0, 1, 0, 0);
    idle(1);
    check("bad_predict_pulse", se_seen - se0, 1);
    check("bad_predict_err_count", int'(err_count), 1);
    check("bad_predict_state", int'(fsm_state), 0);
    seq(97);
    check("after_error_pred_out", int'(pred_out), 113);
    check("after_error_step_count", int'(step_count), 3);

    // 5: latch and update together -> error, no capture
    se0 = se_seen;
    drive(1, 1, 0, 0, 555);
    idle(1);
    check("dual_strobe_pulse", se_seen - se0, 1);
    check("dual_strobe_err_count", int'(err_count), 2);
    check("dual_strobe_state", int'(fsm_state), 0);

    // reset mid-sequence aborts without a publish
    pv0 = pv_seen;
    drive(1, 0, 0, 0, 1000);
    drive(0, 1, 0, 0, 0);
    set_reset(0);
    idle(2);
    set_reset(1);
    idle(2);
    check("abort_pulses", pv_seen - pv0, 0);
    check("abort_step_count", int'(step_count), 0);
    check("abort_state", int'(fsm_state), 0);

    // err_count saturation
    repeat (260) drive(0, 1, 0, 0, 0);
    idle(1);
    check("err_count_saturated", int'(err_count), 255);

    // 6: full-scale measurement for 8 sequences
    set_reset(0);
    idle(2);
    set_reset(1);
    min_seen = 32767;
    after3 = 0;
    for (int i = 0; i < 8; i++) begin
      seq(32767);
      if (int'(pred_out) < min_seen) min_seen = int'(pred_out);
      if (i == 2) after3 = int'(pred_out);
    end
`ifdef PREDICTOR_SAT_EN
    check("sat_third_pred", after3, 32767);
    check("sat_never_negative", int'(min_seen < 0), 0);
    check("sat_final_pred", int'(pred_out), 32767);
`else
    check("wrap_third_pred", after3, -27331);
`endif
    check("fullscale_step_count", int'(step_count), 8);

    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
